// File: rtl/dcdc_pkg.sv
// -----------------------------------------------------------------------------
// dcdc_pkg
// Shared definitions for the DC-DC clocking blocks: the clock-monitor state
// enum, the fault-code enum and the default feedback-period constants. The
// DC-DC clock generator uses the same constants so both sides agree on the
// nominal switching period.
// -----------------------------------------------------------------------------
package dcdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_CHECK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } mon_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_SHORT   = 2'b01,
    FC_LONG    = 2'b10,
    FC_TIMEOUT = 2'b11
  } fault_code_e;

  // 1 MHz feedback at a 20 MHz system clock.
  localparam int DEF_EXP_PERIOD = 20;
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_TIMEOUT    = 40;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/dcdc_clk_mon_if.sv
// -----------------------------------------------------------------------------
// dcdc_clk_mon_if
// Signal bundle between the clock monitor and its controller.
//   enable_i        monitor enable (controller -> monitor)
//   clear_i         single-cycle fault clear request (controller -> monitor)
//   fb_clk_i        asynchronous DC-DC feedback clock (controller -> monitor)
//   locked_o        feedback clock in range (monitor -> controller)
//   fault_o         sticky fault flag (monitor -> controller)
//   fault_code_o    00 none, 01 too short, 10 too long, 11 timeout
//   period_o        last measured period in clk cycles
//   period_valid_o  one-cycle pulse when period_o updates
// Modports: master = controller side, slave = monitor side.
// -----------------------------------------------------------------------------
interface dcdc_clk_mon_if
  import dcdc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             enable_i;
  logic             clear_i;
  logic             fb_clk_i;
  logic             locked_o;
  logic             fault_o;
  logic [1:0]       fault_code_o;
  logic [CNT_W-1:0] period_o;
  logic             period_valid_o;

  modport master (
    output enable_i, clear_i, fb_clk_i,
    input  locked_o, fault_o, fault_code_o, period_o, period_valid_o
  );

  modport slave (
    input  enable_i, clear_i, fb_clk_i,
    output locked_o, fault_o, fault_code_o, period_o, period_valid_o
  );

endinterface

// File: rtl/dcdc_edge_sync.sv
// -----------------------------------------------------------------------------
// dcdc_edge_sync
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous input. edge_o is high for one clk cycle and is consumed at the
// third rising clk edge after the input rises.
//   clk      system clock
//   reset    synchronous, active-high reset
//   async_i  asynchronous input
//   edge_o   one-cycle rising-edge pulse in the clk domain
// -----------------------------------------------------------------------------
module dcdc_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dcdc_clk_mon.sv
// -----------------------------------------------------------------------------
// dcdc_clk_mon
// Monitors the DC-DC feedback clock: measures every period in system-clock
// cycles, locks after LOCK_CNT consecutive in-range periods and raises a
// sticky fault (too short / too long / timeout) if the clock misbehaves
// while locked.
//   clk    system clock (only clock)
//   reset  synchronous, active-high reset
//   mon    dcdc_clk_mon_if.slave: enable_i, clear_i, fb_clk_i in;
//          locked_o, fault_o, fault_code_o, period_o, period_valid_o out
// -----------------------------------------------------------------------------
module dcdc_clk_mon
  import dcdc_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  dcdc_clk_mon_if.slave  mon
);

  localparam int               GW      = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic in_range(input logic [CNT_W-1:0] p);
    return (int'(p) >= EXP_PERIOD - TOL) && (int'(p) <= EXP_PERIOD + TOL);
  endfunction

  function automatic logic too_short(input logic [CNT_W-1:0] p);
    return int'(p) < EXP_PERIOD - TOL;
  endfunction

  logic             edge_w;
  logic             timeout_w;
  logic             report_w;

  mon_state_e       state_q,  state_d;
  fault_code_e      code_q,   code_d;
  logic [GW-1:0]    good_q,   good_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q,     pv_d;
  logic             locked_q, locked_d;
  logic             fault_q,  fault_d;

  dcdc_edge_sync u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (mon.fb_clk_i),
    .edge_o  (edge_w)
  );

  // The counter keeps running past TIMEOUT, so a stuck clock is flagged once.
  assign timeout_w = !edge_w && (cnt_q == CNT_W'(TIMEOUT));

  // The first edge after ACQUIRE only starts a measurement; later edges close one.
  assign report_w  = edge_w && mon.enable_i &&
                     (state_q inside {ST_CHECK, ST_LOCKED, ST_FAULT});

  always_comb begin
    cnt_d    = edge_w ? CNT_W'(1)
             : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    period_d = report_w ? cnt_q : period_q;
    pv_d     = report_w;
    state_d  = state_q;
    good_d   = good_q;
    fault_d  = fault_q;
    code_d   = code_q;

    // Priority: disable, then clear in FAULT, then edge/timeout events.
    if (!mon.enable_i) begin
      state_d = ST_IDLE;
      good_d  = '0;
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end else if (state_q == ST_FAULT && mon.clear_i) begin
      state_d = ST_ACQUIRE;
      good_d  = '0;
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (edge_w) begin
            state_d = ST_CHECK;
            good_d  = '0;
          end
        end
        ST_CHECK: begin
          if (edge_w) begin
            if (in_range(cnt_q)) begin
              if (good_q == GW'(LOCK_CNT - 1)) begin
                state_d = ST_LOCKED;
                good_d  = '0;
              end else begin
                good_d  = good_q + GW'(1);
              end
            end else begin
              good_d = '0;
            end
          end else if (timeout_w) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (edge_w) begin
            if (!in_range(cnt_q)) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
              code_d  = too_short(cnt_q) ? FC_SHORT : FC_LONG;
            end
          end else if (timeout_w) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            code_d  = FC_TIMEOUT;
          end
        end
        ST_FAULT: ;
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      code_q   <= FC_NONE;
      good_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      good_q   <= good_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign mon.locked_o       = locked_q;
  assign mon.fault_o        = fault_q;
  assign mon.fault_code_o   = code_q;
  assign mon.period_o       = period_q;
  assign mon.period_valid_o = pv_q;

endmodule

// File: tb/tb_dcdc_clk_mon.sv
// -----------------------------------------------------------------------------
// tb_dcdc_clk_mon
// Directed scenarios followed by randomized feedback periods, clear pulses,
// enable drops and resets. A timestamp-based reference model predicts the
// monitor outputs every cycle; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_dcdc_clk_mon;

  localparam int EXP = 20;
  localparam int TOL = 1;
  localparam int LCK = 4;
  localparam int TMO = 40;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  localparam int M_IDLE = 0, M_ACQ = 1, M_CHECK = 2, M_LOCKED = 3, M_FAULT = 4;

  logic clk;
  logic reset;

  dcdc_clk_mon_if #(.CNT_W(CW)) bus ();

  dcdc_clk_mon #(
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_CNT   (LCK),
    .TIMEOUT    (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   cyc = 0;
  int   last_load = 0;
  int   gap;
  int   m_st = M_IDLE;
  int   m_good = 0;
  bit   started = 0;
  bit   ev;
  bit   fbh [3];
  int   e_locked = 0, e_fault = 0, e_code = 0, e_per = 0, e_pv = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      started  = 1;
      m_st     = M_IDLE;
      m_good   = 0;
      e_locked = 0; e_fault = 0; e_code = 0; e_per = 0; e_pv = 0;
      fbh[0] = 0; fbh[1] = 0; fbh[2] = 0;
      last_load = cyc + 1;
    end else begin
      // A feedback rise seen at edge n-2 becomes an event at edge n.
      ev  = fbh[1] && !fbh[2];
      gap = cyc - last_load;
      if (gap > SAT) gap = SAT;
      e_pv = 0;
      if (ev && bus.enable_i && (m_st == M_CHECK || m_st == M_LOCKED || m_st == M_FAULT)) begin
        e_per = gap;
        e_pv  = 1;
      end
      if (!bus.enable_i) begin
        m_st = M_IDLE; m_good = 0; e_fault = 0; e_code = 0;
      end else if (m_st == M_FAULT && bus.clear_i) begin
        m_st = M_ACQ; m_good = 0; e_fault = 0; e_code = 0;
      end else begin
        case (m_st)
          M_IDLE: m_st = M_ACQ;
          M_ACQ: if (ev) begin m_st = M_CHECK; m_good = 0; end
          M_CHECK: begin
            if (ev) begin
              if (gap >= EXP - TOL && gap <= EXP + TOL) begin
                m_good++;
                if (m_good == LCK) m_st = M_LOCKED;
              end else m_good = 0;
            end else if (gap == TMO) begin
              m_st = M_ACQ; m_good = 0;
            end
          end
          M_LOCKED: begin
            if (ev) begin
              if (gap < EXP - TOL) begin m_st = M_FAULT; e_fault = 1; e_code = 1; end
              else if (gap > EXP + TOL) begin m_st = M_FAULT; e_fault = 1; e_code = 2; end
            end else if (gap == TMO) begin
              m_st = M_FAULT; e_fault = 1; e_code = 3;
            end
          end
          default: ;
        endcase
      end
      e_locked = (m_st == M_LOCKED);
      if (ev) last_load = cyc;
      fbh[2] = fbh[1];
      fbh[1] = fbh[0];
      fbh[0] = bus.fb_clk_i;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("locked", bus.locked_o, e_locked);
      chk("fault", bus.fault_o, e_fault);
      chk("code", bus.fault_code_o, e_code);
      chk("pvalid", bus.period_valid_o, e_pv);
      if (e_pv != 0) chk("period", bus.period_o, e_per);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One feedback period of p cycles (rise at offset 0); optional clear pulse.
  task automatic fb_period(input int p, input int clr_at);
    for (int i = 0; i < p; i++) begin
      bus.fb_clk_i = (i < p / 2);
      bus.clear_i  = (i == clr_at);
      tick();
    end
    bus.clear_i = 1'b0;
  endtask

  task automatic periods(input int p, input int cnt);
    for (int i = 0; i < cnt; i++) fb_period(p, -1);
  endtask

  int ptab [16] = '{20, 20, 20, 20, 20, 20, 19, 21, 19, 21, 18, 22, 25, 17, 45, 20};

  initial begin
    bus.enable_i = 1'b0;
    bus.clear_i  = 1'b0;
    bus.fb_clk_i = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_locked", bus.locked_o, 0);
    chk("rst_fault", bus.fault_o, 0);
    chk("rst_code", bus.fault_code_o, 0);
    chk("rst_period", bus.period_o, 0);
    chk("rst_pvalid", bus.period_valid_o, 0);
    reset = 1'b0;
    tick();

    // First lock at nominal period.
    bus.enable_i = 1'b1;
    tick();
    periods(20, 6);
    chk("lock1", bus.locked_o, 1);
    chk("lock1_period", bus.period_o, 20);
    chk("lock1_fault", bus.fault_o, 0);

    // Edge-of-tolerance periods keep lock.
    fb_period(19, -1);
    fb_period(21, -1);
    fb_period(20, -1);
    chk("tol_locked", bus.locked_o, 1);

    // Too long.
    fb_period(22, -1);
    fb_period(20, -1);
    chk("long_fault", bus.fault_o, 1);
    chk("long_code", bus.fault_code_o, 2);
    chk("long_locked", bus.locked_o, 0);

    // Clear and relock.
    fb_period(20, 5);
    chk("clr_fault", bus.fault_o, 0);
    periods(20, 6);
    chk("relock", bus.locked_o, 1);

    // Too short.
    fb_period(18, -1);
    fb_period(20, -1);
    chk("short_code", bus.fault_code_o, 1);

    // Clear with disable in the same cycle lands in IDLE.
    bus.clear_i = 1'b1; bus.enable_i = 1'b0;
    tick();
    bus.clear_i = 1'b0;
    chk("dis_fault", bus.fault_o, 0);
    chk("dis_code", bus.fault_code_o, 0);
    tick();
    bus.enable_i = 1'b1;
    tick();

    // Relock, then stuck low -> timeout, then a very long gap saturates.
    periods(20, 6);
    chk("relock2", bus.locked_o, 1);
    fb_period(45, -1);
    chk("tmo_code", bus.fault_code_o, 3);
    fb_period(300, -1);
    fb_period(20, -1);
    chk("sat_period", bus.period_o, SAT);
    chk("sat_code", bus.fault_code_o, 3);

    // Clear, then a bad period inside CHECK delays lock.
    fb_period(20, 5);
    fb_period(20, -1);
    fb_period(20, -1);
    fb_period(25, -1);
    periods(20, 4);
    chk("chk_nolock", bus.locked_o, 0);
    fb_period(20, -1);
    chk("chk_lock", bus.locked_o, 1);

    // Reset while locked.
    fb_period(20, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_locked", bus.locked_o, 0);
    chk("rst2_period", bus.period_o, 0);
    periods(20, 6);
    chk("rst2_relock", bus.locked_o, 1);

    // Randomized phase.
    for (int k = 0; k < 250; k++) begin
      int r, p, clr;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else if (r < 5) begin
        bus.enable_i = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        bus.enable_i = 1'b1;
      end
      p   = ptab[$urandom_range(0, 15)];
      clr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, p - 1)) : -1;
      fb_period(p, clr);
    end
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dcdc_clk_mon.md
DCDC_CLK_MON -- requirements
Module: dcdc_clk_mon

Interface
REQ-001 Parameter EXP_PERIOD, 20, expected feedback clock period in clk cycles (1 MHz at 20 MHz clk).
REQ-002 Parameter TOL, 1, allowed +/- deviation in clk cycles.
REQ-003 Parameter LOCK_CNT, 4, consecutive in-range periods required to lock.
REQ-004 Parameter TIMEOUT, 40, clk cycles without a rising edge that count as a stuck clock.
REQ-005 Parameter CNT_W, 8, period counter width.
REQ-006 clk  input  1  system clock, the only clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable_i  input  1  monitor enable.
REQ-009 clear_i  input  1  single-cycle fault clear request.
REQ-010 fb_clk_i  input  1  asynchronous DC-DC feedback clock being monitored.
REQ-011 locked_o  output  1  feedback clock in range for at least LOCK_CNT periods.
REQ-012 fault_o  output  1  sticky fault flag.
REQ-013 fault_code_o  output  2  00 none, 01 too short, 10 too long, 11 timeout.
REQ-014 period_o  output  CNT_W  last measured period.
REQ-015 period_valid_o  output  1  one-cycle pulse when period_o updates.

Function
REQ-016 fb_clk_i SHALL pass a 2-flop synchronizer, then rising-edge detect; edge pulse SHALL be asserted 3 clk cycles after the input rising edge.
REQ-017 Period counter SHALL load 1 on an edge-pulse cycle, otherwise increment, and saturate at 2^CNT_W-1.
REQ-018 On each edge pulse after the first since entering ACQUIRE, period_o SHALL take the counter value and period_valid_o SHALL pulse in the following cycle.
REQ-019 A period P is in range iff EXP_PERIOD-TOL <= P <= EXP_PERIOD+TOL; P at EXP_PERIOD+/-(TOL+1) SHALL be out of range.
REQ-020 States: IDLE, ACQUIRE, CHECK, LOCKED, FAULT.
REQ-021 IDLE -> ACQUIRE when enable_i=1; any state -> IDLE when enable_i=0, which clears the good count, fault_o, fault_code_o and locked_o.
REQ-022 ACQUIRE -> CHECK on first edge pulse; no period reported.
REQ-023 In CHECK, an in-range period SHALL increment the good count; reaching LOCK_CNT -> LOCKED; out-of-range SHALL zero the good count and stay in CHECK; a timeout SHALL go to ACQUIRE without fault.
REQ-024 In LOCKED, locked_o=1; an out-of-range period or timeout (counter == TIMEOUT without an edge) SHALL go to FAULT, with fault_o=1, locked_o=0 and fault_code_o set, in the next cycle.
REQ-025 FAULT SHALL hold fault_o and fault_code_o until clear_i=1, then go to ACQUIRE with both cleared.
REQ-026 clear_i in any state other than FAULT SHALL have no effect.
REQ-027 In FAULT, measurement SHALL continue (period_o updates) but SHALL NOT change fault_code_o.
REQ-028 enable_i=0 SHALL take priority over clear_i, and both SHALL take priority over edge events in the same cycle.

Reset
REQ-029 On reset=1 at a clk edge: state=IDLE, synchronizer and counters=0, locked_o=0, fault_o=0, fault_code_o=00, period_o=0, period_valid_o=0.
REQ-030 Reset asserted mid-measurement SHALL discard partial counts; after release, monitoring SHALL restart from IDLE/ACQUIRE.

Structure
REQ-031 Shared package dcdc_pkg SHALL hold the state enum, the fault-code enum and the default period constants, also used by the DC-DC clock generator.
REQ-032 Synchronizer plus edge detector SHALL be the sub-module dcdc_edge_sync; the FSM, counter and range check stay in dcdc_clk_mon.

Verification
REQ-033 fb_clk_i with period 20 and enable_i=1 -> period_o=20; locked_o=1 after the 4th in-range period; fault_o=0.
REQ-034 Locked, then one period of 22 -> fault_o=1, fault_code_o=10, locked_o=0; a period of 18 instead -> fault_code_o=01; periods of 19 and 21 -> stay locked.
REQ-035 Locked, fb_clk_i held low -> fault_code_o=11 when the counter reaches 40 without an edge.
REQ-036 In FAULT, clear_i pulse -> fault_o=0 next cycle; relock after 4 good periods; clear_i and enable_i=0 in the same cycle -> IDLE.
REQ-037 In CHECK, periods 20,20,25,20,20,20,20 -> lock only after the 4th period following the 25.
REQ-038 reset pulse while LOCKED -> all outputs at reset values next cycle; relock sequence identical to the first lock.
